// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers,
// with exact occupancy tracking. Optional sticky error detect: FIFO_WR_ARB_ERR_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wr_n,
   output logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          rd_n,
   output logic [CNT_W-1:0]              count,
   output logic                          full,
   output logic                          empty,
   output logic                          err
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]      ptr, win;
   logic                  found, grant, pend, inc, dec;
   logic [CNT_W:0]        occ;
   logic [DATA_WIDTH-1:0] slice [NUM_REQ];

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_slice
         assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // The strobe currently on the bus is not yet in count, so reserve room for it.
   assign pend  = ~wr_n;
   assign occ   = {1'b0, count} + (CNT_W+1)'(pend);
   assign grant = (|req) && (occ < (CNT_W+1)'(DEPTH));
   assign inc   = ~wr_n;
   assign dec   = ~rd_n && (count != '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_comb begin
      found = 1'b0;
      win   = ptr;
      for (int off = 1; off <= NUM_REQ; off++) begin
         int idx;
         idx = (int'(ptr) + off) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt     <= '0;
         wr_n    <= 1'b1;
         data_in <= '0;
         ptr     <= PTR_W'(NUM_REQ-1);
         count   <= '0;
      end else begin
         count <= count + CNT_W'(inc) - CNT_W'(dec);
         if (grant) begin
            gnt     <= NUM_REQ'(1) << win;
            wr_n    <= 1'b0;
            data_in <= slice[win];
            ptr     <= win;
         end else begin
            gnt  <= '0;
            wr_n <= 1'b1;
         end
      end
   end

`ifdef FIFO_WR_ARB_ERR_EN
   logic err_q;
   // Underflow attempt, or a grant that would overrun the FIFO (must never happen).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if ((!rd_n && count == '0) || ((|req) && occ > (CNT_W+1)'(DEPTH)))
         err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
